// File: rtl/av_master_arbiter.sv
// Two-requester Avalon-MM arbiter: grants one whole transfer at a time to the
// MCU bridge (s0) or the debug supervisor (s1), with a stuck-slave watchdog.
module av_master_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 16,
    parameter int TIMEOUT     = 1024,
    parameter int S1_PRIORITY = 0
) (
    input  logic                  sysclk,
    input  logic                  sysreset,
    input  logic [ADDR_WIDTH-1:0] s0_address,
    input  logic                  s0_read,
    input  logic                  s0_write,
    input  logic [DATA_WIDTH-1:0] s0_writedata,
    output logic                  s0_waitrequest,
    output logic [DATA_WIDTH-1:0] s0_readdata,
    input  logic [ADDR_WIDTH-1:0] s1_address,
    input  logic                  s1_read,
    input  logic                  s1_write,
    input  logic [DATA_WIDTH-1:0] s1_writedata,
    output logic                  s1_waitrequest,
    output logic [DATA_WIDTH-1:0] s1_readdata,
    output logic [ADDR_WIDTH-1:0] m_address,
    output logic                  m_read,
    output logic                  m_write,
    output logic [DATA_WIDTH-1:0] m_writedata,
    input  logic                  m_waitrequest,
    input  logic [DATA_WIDTH-1:0] m_readdata,
    output logic [1:0]            grant,
    output logic                  timeout_err
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            req0, req1;
    logic            gsel;
    logic            cur_req;
    logic            abort;
    logic            wait_g;
    logic [DATA_WIDTH-1:0] rdata_g;

    assign req0 = s0_read | s0_write;
    assign req1 = s1_read | s1_write;

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        cnt_d          = cnt_q;
        m_address      = '0;
        m_read         = 1'b0;
        m_write        = 1'b0;
        m_writedata    = '0;
        grant          = 2'b00;
        timeout_err    = 1'b0;
        gsel           = (state_q == GRANT1);
        cur_req        = gsel ? req1 : req0;
        abort          = 1'b0;
        wait_g         = 1'b1;
        rdata_g        = m_readdata;
        s0_waitrequest = 1'b1;
        s1_waitrequest = 1'b1;
        s0_readdata    = m_readdata;
        s1_readdata    = m_readdata;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req0 && req1) begin
                    // last_q names the requester served most recently
                    state_d = ((S1_PRIORITY != 0) || !last_q) ? GRANT1 : GRANT0;
                end else if (req0) begin
                    state_d = GRANT0;
                end else if (req1) begin
                    state_d = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                grant       = gsel ? 2'b10 : 2'b01;
                m_address   = gsel ? s1_address   : s0_address;
                m_read      = gsel ? s1_read      : s0_read;
                m_write     = gsel ? s1_write     : s0_write;
                m_writedata = gsel ? s1_writedata : s0_writedata;
                wait_g      = m_waitrequest;
                abort       = (TIMEOUT > 0) && cur_req && m_waitrequest && (cnt_q == CNT_LAST);
                if (!cur_req) begin
                    // requester abandoned the transfer; fairness pointer untouched
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!m_waitrequest) begin
                    state_d = IDLE;
                    last_d  = gsel;
                    cnt_d   = '0;
                end else if (abort) begin
                    wait_g      = 1'b0;
                    rdata_g     = {DATA_WIDTH{1'b1}};
                    timeout_err = 1'b1;
                    state_d     = IDLE;
                    last_d      = gsel;
                    cnt_d       = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (gsel) begin
                    s1_waitrequest = wait_g;
                    s1_readdata    = rdata_g;
                end else begin
                    s0_waitrequest = wait_g;
                    s0_readdata    = rdata_g;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // No requester may complete a transfer while reset is held.
        if (sysreset) begin
            s0_waitrequest = 1'b1;
            s1_waitrequest = 1'b1;
            timeout_err    = 1'b0;
        end
    end

endmodule
